// File: rtl/digital_clock_param.sv
// -----------------------------------------------------------------------------
// digital_clock_param
//   Time-of-day counter (HH:MM:SS) fed by a timebase tick. It has a tick
//   prescaler, a 12/24-hour display mapping, a synchronous time load with a
//   range check, a day-rollover pulse and an HH:MM alarm with auto-timeout.
//
// Parameters
//   TICKS_PER_SEC  tick_en pulses per one-second advance (>= 1)
//   ALARM_LEN      seconds the alarm stays active if not acknowledged (>= 1)
//
// Ports
//   Clk_1sec       in   clock, all logic on the rising edge
//   reset          in   synchronous active-high reset
//   tick_en        in   timebase tick
//   mode_12h       in   1 = 12-hour display, 0 = 24-hour display
//   set_en         in   one-cycle load strobe for set_hours/minutes/seconds
//   set_hours      in   load hour (0..23, 24 h format)
//   set_minutes    in   load minute (0..59)
//   set_seconds    in   load second (0..59)
//   alarm_en       in   alarm armed
//   alarm_hours    in   alarm hour (24 h format)
//   alarm_minutes  in   alarm minute
//   alarm_ack      in   clears an active alarm
//   seconds        out  0..59
//   minutes        out  0..59
//   hours          out  0..23 (24 h) or 1..12 (12 h)
//   pm             out  internal hour >= 12
//   day_tick       out  one-cycle pulse when the time reads 00:00:00 after rollover
//   alarm          out  alarm active level
//   set_err        out  one-cycle pulse after an out-of-range load
// -----------------------------------------------------------------------------
module digital_clock_param #(
  parameter int TICKS_PER_SEC = 1,
  parameter int ALARM_LEN     = 60
) (
  input  logic       Clk_1sec,
  input  logic       reset,
  input  logic       tick_en,
  input  logic       mode_12h,
  input  logic       set_en,
  input  logic [4:0] set_hours,
  input  logic [5:0] set_minutes,
  input  logic [5:0] set_seconds,
  input  logic       alarm_en,
  input  logic [4:0] alarm_hours,
  input  logic [5:0] alarm_minutes,
  input  logic       alarm_ack,
  output logic [5:0] seconds,
  output logic [5:0] minutes,
  output logic [4:0] hours,
  output logic       pm,
  output logic       day_tick,
  output logic       alarm,
  output logic       set_err
);

  // A prescaler of one tick still needs a 1-bit counter that simply stays 0.
  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int AW = $clog2(ALARM_LEN + 1);

  localparam logic [PW-1:0] PCNT_MAX   = PW'(TICKS_PER_SEC - 1);
  localparam logic [PW-1:0] PCNT_ONE   = PW'(1);
  localparam logic [PW-1:0] PCNT_ZERO  = PW'(0);
  localparam logic [AW-1:0] ACNT_LOAD  = AW'(ALARM_LEN);
  localparam logic [AW-1:0] ACNT_ONE   = AW'(1);
  localparam logic [AW-1:0] ACNT_ZERO  = AW'(0);

  // Load values are valid only when every field is a legal time of day.
  function automatic logic set_in_range(input logic [4:0] h,
                                        input logic [5:0] m,
                                        input logic [5:0] s);
    set_in_range = (h <= 5'd23) && (m <= 6'd59) && (s <= 6'd59);
  endfunction

  // An alarm setting outside the day never matches.
  function automatic logic alarm_in_range(input logic [4:0] h,
                                          input logic [5:0] m);
    alarm_in_range = (h <= 5'd23) && (m <= 6'd59);
  endfunction

  logic [5:0]    sec_r, sec_s;
  logic [5:0]    min_r, min_s;
  logic [4:0]    hr_r, hr_s;
  logic [PW-1:0] pcnt_r, pcnt_s;
  logic [AW-1:0] acnt_r, acnt_s;
  logic          alarm_r, alarm_s;
  logic          day_tick_r, day_tick_s;
  logic          set_err_r, set_err_s;
  logic          advance_s;
  logic          trigger_s;

  // Next-state: load has priority over tick; an invalid load freezes all state.
  always_comb begin
    sec_s      = sec_r;
    min_s      = min_r;
    hr_s       = hr_r;
    pcnt_s     = pcnt_r;
    acnt_s     = acnt_r;
    alarm_s    = alarm_r;
    day_tick_s = 1'b0;
    set_err_s  = 1'b0;
    advance_s  = 1'b0;
    trigger_s  = 1'b0;

    if (set_en) begin
      if (set_in_range(set_hours, set_minutes, set_seconds)) begin
        sec_s   = set_seconds;
        min_s   = set_minutes;
        hr_s    = set_hours;
        pcnt_s  = PCNT_ZERO;
        acnt_s  = ACNT_ZERO;
        alarm_s = 1'b0;
      end else begin
        set_err_s = 1'b1;
      end
    end else begin
      if (tick_en) begin
        if (pcnt_r == PCNT_MAX) begin
          pcnt_s    = PCNT_ZERO;
          advance_s = 1'b1;
        end else begin
          pcnt_s = pcnt_r + PCNT_ONE;
        end
      end else begin
        pcnt_s = pcnt_r;
      end

      if (advance_s) begin
        if (sec_r == 6'd59) begin
          sec_s = 6'd0;
          if (min_r == 6'd59) begin
            min_s = 6'd0;
            if (hr_r == 5'd23) begin
              hr_s       = 5'd0;
              day_tick_s = 1'b1;
            end else begin
              hr_s = hr_r + 5'd1;
            end
          end else begin
            min_s = min_r + 6'd1;
          end
        end else begin
          sec_s = sec_r + 6'd1;
        end
      end else begin
        sec_s = sec_r;
      end

      // Trigger compares against the time being entered on this edge.
      trigger_s = advance_s && alarm_en &&
                  alarm_in_range(alarm_hours, alarm_minutes) &&
                  (sec_s == 6'd0) && (min_s == alarm_minutes) &&
                  (hr_s == alarm_hours);

      // A trigger outranks ack on the same edge.
      if (trigger_s) begin
        alarm_s = 1'b1;
        acnt_s  = ACNT_LOAD;
      end else if (alarm_r) begin
        if (alarm_ack || !alarm_en) begin
          alarm_s = 1'b0;
          acnt_s  = ACNT_ZERO;
        end else if (advance_s) begin
          if (acnt_r <= ACNT_ONE) begin
            alarm_s = 1'b0;
            acnt_s  = ACNT_ZERO;
          end else begin
            acnt_s = acnt_r - ACNT_ONE;
          end
        end else begin
          acnt_s = acnt_r;
        end
      end else begin
        acnt_s = acnt_r;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge Clk_1sec) begin
    if (reset) begin
      sec_r      <= 6'd0;
      min_r      <= 6'd0;
      hr_r       <= 5'd0;
      pcnt_r     <= PCNT_ZERO;
      acnt_r     <= ACNT_ZERO;
      alarm_r    <= 1'b0;
      day_tick_r <= 1'b0;
      set_err_r  <= 1'b0;
    end else begin
      sec_r      <= sec_s;
      min_r      <= min_s;
      hr_r       <= hr_s;
      pcnt_r     <= pcnt_s;
      acnt_r     <= acnt_s;
      alarm_r    <= alarm_s;
      day_tick_r <= day_tick_s;
      set_err_r  <= set_err_s;
    end
  end

  // Display mapping: 12 h shows hour 0 as 12 and folds 13..23 down by 12.
  always_comb begin
    hours = hr_r;
    if (mode_12h) begin
      if (hr_r == 5'd0) begin
        hours = 5'd12;
      end else if (hr_r > 5'd12) begin
        hours = hr_r - 5'd12;
      end else begin
        hours = hr_r;
      end
    end else begin
      hours = hr_r;
    end
  end

  assign pm       = (hr_r >= 5'd12);
  assign seconds  = sec_r;
  assign minutes  = min_r;
  assign day_tick = day_tick_r;
  assign alarm    = alarm_r;
  assign set_err  = set_err_r;

endmodule
